// File: rtl/event_queue_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : event_queue_bank_pkg
// Purpose  : Shared sensor geometry, partition index widths and the event
//            record carried from the partitioner into the queue bank.
// Revision : 1.0 - initial release
// ============================================================================
package event_queue_bank_pkg;

   localparam int SENSOR_WIDTH    = 640;
   localparam int SENSOR_HEIGHT   = 480;
   localparam int XY_BITS         = 10;
   localparam int TS_BITS         = 32;

   localparam int DEF_X_DIVISIONS = 4;
   localparam int DEF_Y_DIVISIONS = 4;

   // One spare bit beyond the partition count so the partitioner can
   // express an out-of-range destination that the bank then discards.
   localparam int X_DIV_BITS      = 3;
   localparam int Y_DIV_BITS      = 3;

   typedef struct packed {
      logic [XY_BITS-1:0] x;
      logic [XY_BITS-1:0] y;
      logic               polarity;
      logic [TS_BITS-1:0] timestamp;
   } event_t;

endpackage
`default_nettype wire

// File: rtl/event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : event_fifo
// Purpose  : Single first-word-fall-through queue of events. The head is
//            combinationally visible whenever the queue holds data.
// Revision : 1.0 - initial release
// ============================================================================
module event_fifo
   import event_queue_bank_pkg::*;
#(
   parameter int  DEPTH = 16,
   parameter type T     = event_t,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  T              push_data,
   output logic          full,
   input  logic          pop,
   output logic          empty,
   output T              head,
   output logic [CW-1:0] count
);

   T              r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign full      = (r_count == CW'(DEPTH));
   assign empty     = (r_count == '0);
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;
   assign head      = r_mem[r_rd_ptr];
   assign count     = r_count;

   // Pointer and fill-level update; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage write; contents survive reset, only the pointers are cleared.
   always_ff @(posedge clk) begin
      if (w_do_push && !rst) r_mem[r_wr_ptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/event_queue_bank.sv
`default_nettype none
// ============================================================================
// Module   : event_queue_bank
// Purpose  : Bank of per-partition event queues. Decodes the partition
//            destination, applies the full-queue policy (stall or drop) and
//            keeps a saturating count of discarded events.
// Revision : 1.0 - initial release
// ============================================================================
module event_queue_bank
   import event_queue_bank_pkg::*;
#(
   parameter int  X_DIVISIONS    = DEF_X_DIVISIONS,
   parameter int  Y_DIVISIONS    = DEF_Y_DIVISIONS,
   parameter int  DEPTH          = 16,
   parameter int  DROP_WHEN_FULL = 0,
   localparam int N              = X_DIVISIONS * Y_DIVISIONS,
   localparam int CW             = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  event_t                in_event,
   input  logic [X_DIV_BITS-1:0] in_x_dest,
   input  logic [Y_DIV_BITS-1:0] in_y_dest,
   output logic [N-1:0]          out_valid,
   input  logic [N-1:0]          out_ready,
   output event_t [N-1:0]        out_event,
   output logic [N-1:0][CW-1:0]  occupancy,
   output logic [15:0]           drop_count
);

   logic         w_dest_ok;
   logic [N-1:0] w_sel;
   logic [N-1:0] w_full;
   logic [N-1:0] w_empty;
   logic         w_tgt_full;
   logic         w_accept;
   logic         w_drop;
   logic [15:0]  r_drop_count;

   assign w_dest_ok  = (int'(in_x_dest) < X_DIVISIONS) && (int'(in_y_dest) < Y_DIVISIONS);
   assign w_tgt_full = |(w_full & w_sel);

   // Ready depends only on the destination and registered fill state, never
   // on out_ready, so a same-cycle pop cannot open space for a push.
   assign in_ready   = (!w_dest_ok || (DROP_WHEN_FULL != 0)) ? 1'b1 : !w_tgt_full;
   assign w_accept   = in_valid && in_ready;
   assign w_drop     = w_accept && (!w_dest_ok || w_tgt_full);
   assign drop_count = r_drop_count;

   generate
      for (genvar i = 0; i < N; i++) begin : g_queue
         localparam int QX = i % X_DIVISIONS;
         localparam int QY = i / X_DIVISIONS;

         assign w_sel[i] = w_dest_ok
                        && (in_x_dest == X_DIV_BITS'(QX))
                        && (in_y_dest == Y_DIV_BITS'(QY));

         event_fifo #(
            .DEPTH (DEPTH),
            .T     (event_t)
         ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (w_accept && w_sel[i] && !w_full[i]),
            .push_data (in_event),
            .full      (w_full[i]),
            .pop       (out_ready[i]),
            .empty     (w_empty[i]),
            .head      (out_event[i]),
            .count     (occupancy[i])
         );

         assign out_valid[i] = !w_empty[i];
      end
   endgenerate

   // Saturating count of events discarded for bad destination or full queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_drop_count <= '0;
      end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
         r_drop_count <= r_drop_count + 16'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_event_queue_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_event_queue_bank
// Purpose  : Self-checking bench for event_queue_bank. Two instances share
//            the stimulus: one in stall mode, one in drop-and-count mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_event_queue_bank;
   import event_queue_bank_pkg::*;

   localparam int N  = 16;
   localparam int CW = 5;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid;
   event_t                in_event;
   logic [X_DIV_BITS-1:0] in_x_dest;
   logic [Y_DIV_BITS-1:0] in_y_dest;
   logic [N-1:0]          out_ready;

   logic                  ready_bp, ready_dr;
   logic [N-1:0]          valid_bp, valid_dr;
   event_t [N-1:0]        ev_bp, ev_dr;
   logic [N-1:0][CW-1:0]  occ_bp, occ_dr;
   logic [15:0]           drop_bp, drop_dr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   event_queue_bank #(.DROP_WHEN_FULL(0)) u_dut_bp (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_bp),
      .in_event(in_event), .in_x_dest(in_x_dest), .in_y_dest(in_y_dest),
      .out_valid(valid_bp), .out_ready(out_ready), .out_event(ev_bp),
      .occupancy(occ_bp), .drop_count(drop_bp)
   );

   event_queue_bank #(.DROP_WHEN_FULL(1)) u_dut_dr (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_dr),
      .in_event(in_event), .in_x_dest(in_x_dest), .in_y_dest(in_y_dest),
      .out_valid(valid_dr), .out_ready(out_ready), .out_event(ev_dr),
      .occupancy(occ_dr), .drop_count(drop_dr)
   );

   typedef struct {
      logic       vld;
      logic [2:0] xd;
      logic [2:0] yd;
      int         pop_q;
      logic       exp_rdy;
      int         chk_q;
      int         exp_occ;
      int         exp_drop;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic vld, input logic [2:0] xd, input logic [2:0] yd,
                        input int ts, input int ex, input int ey);
      in_valid           = vld;
      in_x_dest          = xd;
      in_y_dest          = yd;
      in_event.x         = XY_BITS'(ex);
      in_event.y         = XY_BITS'(ey);
      in_event.polarity  = ts[0];
      in_event.timestamp = TS_BITS'(ts);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b0;
      out_ready = '0;
      drive(1'b0, 3'd0, 3'd0, 0, 0, 0);

      vecs[0] = '{1'b1, 3'd1, 3'd2, -1, 1'b1,  9, 1, 0};
      vecs[1] = '{1'b1, 3'd3, 3'd3, -1, 1'b1, 15, 1, 0};
      vecs[2] = '{1'b1, 3'd4, 3'd0, -1, 1'b1,  0, 0, 1};
      vecs[3] = '{1'b1, 3'd0, 3'd4, -1, 1'b1,  0, 0, 2};
      vecs[4] = '{1'b1, 3'd1, 3'd2, -1, 1'b1,  9, 2, 2};
      vecs[5] = '{1'b0, 3'd1, 3'd2,  9, 1'b1,  9, 1, 2};
      vecs[6] = '{1'b1, 3'd1, 3'd2,  9, 1'b1,  9, 1, 2};
      vecs[7] = '{1'b0, 3'd0, 3'd0, 15, 1'b1, 15, 0, 2};
      vecs[8] = '{1'b0, 3'd0, 3'd0, 15, 1'b1, 15, 0, 2};
      vecs[9] = '{1'b1, 3'd3, 3'd0, -1, 1'b1,  3, 1, 2};

      @(posedge clk); #1;
      do_reset();

      // Reset state of both instances
      chk("rst_valid_bp", 64'(valid_bp), 64'h0);
      chk("rst_valid_dr", 64'(valid_dr), 64'h0);
      chk("rst_ready_bp", 64'(ready_bp), 64'h1);
      chk("rst_drop_bp",  64'(drop_bp),  64'h0);
      chk("rst_occ_bp",   64'(occ_bp),   64'h0);

      // Single event to (1,2) lands in queue 9 one cycle later
      drive(1'b1, 3'd1, 3'd2, 7, 10, 20);
      tick();
      drive(1'b0, 3'd0, 3'd0, 0, 0, 0);
      chk("first_valid", 64'(valid_bp), 64'h0200);
      chk("first_occ9",  64'(occ_bp[9]), 64'd1);
      chk("first_x",     64'(ev_bp[9].x), 64'd10);
      chk("first_y",     64'(ev_bp[9].y), 64'd20);

      // Table-driven single-cycle vectors
      do_reset();
      for (int i = 0; i < 10; i++) begin
         out_ready = '0;
         if (vecs[i].pop_q >= 0) out_ready[vecs[i].pop_q] = 1'b1;
         drive(vecs[i].vld, vecs[i].xd, vecs[i].yd, 200 + i, i, i);
         chk($sformatf("vec%0d_ready", i), 64'(ready_bp), 64'(vecs[i].exp_rdy));
         tick();
         out_ready = '0;
         drive(1'b0, 3'd0, 3'd0, 0, 0, 0);
         chk($sformatf("vec%0d_occ", i),  64'(occ_bp[vecs[i].chk_q]), 64'(vecs[i].exp_occ));
         chk($sformatf("vec%0d_drop", i), 64'(drop_bp), 64'(vecs[i].exp_drop));
      end

      // Backpressure: fill queue 0, hold the 17th, pop once, drain in order
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         drive(1'b1, 3'd0, 3'd0, k, 0, 0);
         chk($sformatf("bp_ready_push%0d", k), 64'(ready_bp), 64'h1);
         tick();
      end
      drive(1'b1, 3'd0, 3'd0, 17, 0, 0);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bp_ready_held%0d", k), 64'(ready_bp), 64'h0);
         tick();
      end
      chk("bp_occ_full", 64'(occ_bp[0]), 64'd16);
      out_ready[0] = 1'b1;
      #1;
      chk("bp_head_first", 64'(ev_bp[0].timestamp), 64'd1);
      chk("bp_ready_during_pop", 64'(ready_bp), 64'h0);
      tick();
      out_ready[0] = 1'b0;
      #1;
      chk("bp_occ_after_pop", 64'(occ_bp[0]), 64'd15);
      chk("bp_ready_after_pop", 64'(ready_bp), 64'h1);
      tick();
      drive(1'b0, 3'd0, 3'd0, 0, 0, 0);
      chk("bp_occ_17th", 64'(occ_bp[0]), 64'd16);
      chk("bp_ready_refull", 64'(ready_bp), 64'h0);
      out_ready[0] = 1'b1;
      for (int k = 2; k <= 17; k++) begin
         #1;
         chk($sformatf("bp_drain%0d", k), 64'(ev_bp[0].timestamp), 64'(k));
         tick();
      end
      out_ready[0] = 1'b0;
      #1;
      chk("bp_drained", 64'(occ_bp[0]), 64'd0);

      // Drop mode: 20 events into queue 3, no pops
      do_reset();
      for (int k = 0; k < 20; k++) begin
         drive(1'b1, 3'd3, 3'd0, k, 0, 0);
         chk($sformatf("dr_ready%0d", k), 64'(ready_dr), 64'h1);
         tick();
      end
      drive(1'b0, 3'd0, 3'd0, 0, 0, 0);
      chk("dr_occ3",  64'(occ_dr[3]), 64'd16);
      chk("dr_drops", 64'(drop_dr), 64'd4);
      chk("dr_head",  64'(ev_dr[3].timestamp), 64'd0);

      // Concurrent push and pop on queue 5 at occupancy 8
      do_reset();
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 3'd1, 3'd1, 100 + k, 0, 0);
         tick();
      end
      out_ready[5] = 1'b1;
      drive(1'b1, 3'd1, 3'd1, 108, 0, 0);
      chk("cc_occ_before", 64'(occ_bp[5]), 64'd8);
      chk("cc_popped_oldest", 64'(ev_bp[5].timestamp), 64'd100);
      tick();
      out_ready = '0;
      drive(1'b0, 3'd0, 3'd0, 0, 0, 0);
      chk("cc_occ_after", 64'(occ_bp[5]), 64'd8);
      chk("cc_new_head",  64'(ev_bp[5].timestamp), 64'd101);

      // Mid-stream reset with three partially filled queues
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 3'(k), 3'd0, 40 + k, 0, 0);
         tick();
      end
      drive(1'b1, 3'd4, 3'd0, 0, 0, 0);
      tick();
      chk("mr_pre_drop", 64'(drop_bp), 64'd1);
      chk("mr_pre_valid", 64'(valid_bp), 64'h0007);
      rst = 1'b1;
      drive(1'b1, 3'd3, 3'd1, 77, 0, 0);
      tick();
      rst = 1'b0;
      drive(1'b0, 3'd0, 3'd0, 0, 0, 0);
      chk("mr_valid_bp", 64'(valid_bp), 64'h0);
      chk("mr_valid_dr", 64'(valid_dr), 64'h0);
      chk("mr_occ_bp",   64'(occ_bp),   64'h0);
      chk("mr_drop_bp",  64'(drop_bp),  64'h0);
      chk("mr_ready_bp", 64'(ready_bp), 64'h1);
      drive(1'b1, 3'd3, 3'd1, 55, 0, 0);
      tick();
      drive(1'b0, 3'd0, 3'd0, 0, 0, 0);
      chk("mr_post_valid", 64'(valid_bp), 64'h0080);
      chk("mr_post_occ7",  64'(occ_bp[7]), 64'd1);
      chk("mr_post_head",  64'(ev_bp[7].timestamp), 64'd55);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/event_queue_bank.md
# event_queue_bank

Bank of per-partition event FIFOs directly downstream of the event partitioner. It accepts one sensor event per cycle, together with its precomputed partition coordinates (x_dest, y_dest). It stores the event in the FIFO for that partition and presents each FIFO to its own event handler through an independent valid/ready port. Full partitions are handled by one of two policies: stall the stream or drop and count.

## Interface
Parameters:
- X_DIVISIONS, default 4: horizontal partition count.
- Y_DIVISIONS, default 4: vertical partition count.
- DEPTH, default 16: entries per FIFO; power of two, ≥ 2.
- DROP_WHEN_FULL, default 0: 0 = backpressure upstream; 1 = never stall, drop and count.
- N = X_DIVISIONS*Y_DIVISIONS: derived, not overridable.

Ports:
- clk, in, 1: single clock. All logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: input event present.
- in_ready, out, 1: input accepted this cycle when in_valid && in_ready.
- in_event, in, event_t: event (x, y, polarity, timestamp).
- in_x_dest, in, X_DIV_BITS: partition column from the partitioner.
- in_y_dest, in, Y_DIV_BITS: partition row from the partitioner.
- out_valid, out, [N]: queue q non-empty.
- out_ready, in, [N]: handler q pops the head this cycle.
- out_event, out, event_t [N]: head of queue q.
- occupancy, out, [N][$clog2(DEPTH+1)]: current fill level of each queue.
- drop_count, out, 16: saturating count of dropped events.

## Operation
- Queue index: q = in_y_dest*X_DIVISIONS + in_x_dest.
- Invalid destination: in_x_dest ≥ X_DIVISIONS or in_y_dest ≥ Y_DIVISIONS.
  - The event is accepted (in_ready=1), discarded, and drop_count increments.
  - This applies in both modes.
- DROP_WHEN_FULL=0:
  - in_ready = !full[q].
  - Readiness is based on registered state only; a pop on q in the same cycle does not free space for the push.
- DROP_WHEN_FULL=1:
  - in_ready = 1 at all times.
  - An event targeting a full queue is discarded and drop_count increments.
- Push:
  - Writes mem[q][wr_ptr[q]].
  - wr_ptr increments and wraps modulo DEPTH.
  - occupancy[q] increments.
- Pop: when out_valid[q] && out_ready[q], rd_ptr[q] increments (wraps) and occupancy[q] decrements.
- Simultaneous push and pop on the same non-full, non-empty queue: occupancy unchanged, both pointers advance.
- out_ready[q] while out_valid[q]=0 is ignored.
- full[q] = (occupancy[q]==DEPTH); out_valid[q] = (occupancy[q]!=0).
- out_event[q] = mem[q][rd_ptr[q]] (first-word-fall-through). It is undefined while out_valid[q]=0.
- drop_count saturates at 16'hFFFF.
- Event ordering is FIFO per queue. There is no ordering guarantee across queues.

## Timing
- Latency: an event accepted in cycle n is visible at out_valid/out_event of its queue in cycle n+1.
- Throughput: 1 push per cycle in total, plus 1 pop per queue per cycle.
- in_ready is combinational from in_x_dest/in_y_dest and registered occupancy. It does not depend on out_ready.
- Upstream handshake obligation: the producer holds in_event and the dest fields stable while in_valid && !in_ready.
- Downstream handshake guarantee: out_event[q] is stable while out_valid[q] && !out_ready[q].
- Reset takes effect in the cycle rst is sampled high, including mid-stream. It clears:
  - all pointers and occupancy to 0;
  - out_valid to all zeros;
  - drop_count to 0;
  - in_ready to 1 (queues empty).
  - Memory contents are not cleared.
- Events presented during the reset cycle are not stored and not counted.

## Structure
- Shared globals package holds: event_t, XY_BITS, X_DIV_BITS, Y_DIV_BITS, SENSOR_WIDTH, SENSOR_HEIGHT, default X_DIVISIONS/Y_DIVISIONS.
- Sub-module event_fifo:
  - Single-queue FWFT FIFO, parameters DEPTH and element type event_t.
  - Ports: push, full, pop, empty, head, count.
  - Instantiated N times via generate.
- The top level holds dest decode, the ready/drop policy, and the drop counter.

## Test plan
- Reset, then one event (x=10, y=20) with dest (1,2) at defaults → out_valid[9]=1 the next cycle, occupancy[9]=1, other queues empty.
- DROP_WHEN_FULL=0, out_ready[0]=0:
  - Push 16 events to dest (0,0) → in_ready drops to 0 after the 16th push and stays low.
  - With the 17th event held, raise out_ready[0] for one cycle → the 17th is accepted the cycle after the pop.
  - Order on drain is 1..17.
- DROP_WHEN_FULL=1: push 20 events to full-pending queue 3 with no pops → occupancy[3]=16, drop_count=4, in_ready constantly 1.
- Concurrent push to q=5 and pop from q=5 at occupancy 8 → occupancy stays 8, the popped event is the oldest.
- Invalid dest (x_dest=4) → accepted, drop_count +1, no queue changes.
- Assert rst with 3 queues partially full → next cycle all out_valid=0, occupancy=0, drop_count=0. A post-reset push works normally.
